// File: rtl/rll_key_pkg.sv
// Shared types and helpers for the RLL unlock-key loader.
package rll_key_pkg;

  localparam int KEY_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // XOR-reduce; callers zero-extend narrower keys, which leaves the result unchanged.
  function automatic logic parity_of(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rll_key_loader.sv
// Serially loads, parity-checks and holds the unlock key for an RLL-locked core; commit lands one
// edge after the parity beat, and sin_ready drops outside SHIFT so the source simply stalls.
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             sin_data,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_done,
  output logic             load_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] shreg;
  logic             par;
  logic             parity_ok;

  assign parity_ok = (parity_of(64'(shreg)) == par);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs depend on state alone, so sin_valid never feeds back combinationally.
  always_comb begin
    state_nxt = state;
    sin_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        sin_ready = 1'b1;
        busy      = 1'b1;
        if (!load_start && sin_valid && (cnt == CNT_LAST)) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        busy      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            cnt      <= '0;
            shreg    <= '0;
            load_err <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // A restart outranks a beat arriving on the same edge; that beat is dropped.
          if (load_start) begin
            cnt      <= '0;
            shreg    <= '0;
            load_err <= 1'b0;
          end else if (sin_valid) begin
            if (cnt == CNT_LAST) begin
              par <= sin_data;
            end else begin
              for (int i = 0; i < KEY_W; i++) begin
                if (cnt == CNT_W'(i)) shreg[i] <= sin_data;
              end
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (parity_ok) begin
            key_out   <= shreg;
            key_valid <= 1'b1;
            load_done <= 1'b1;
          end else begin
            load_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader: hand-computed keys/parities, checked at the falling edge.
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        sin_valid;
  logic        sin_ready;
  logic        sin_data;
  logic [15:0] key_out;
  logic        key_valid;
  logic        load_done;
  logic        load_err;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int cycles;
  int done_seen;

  rll_key_loader #(.KEY_W(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready),
    .sin_data   (sin_data),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .load_done  (load_done),
    .load_err   (load_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic b);
    sin_valid = 1'b1;
    sin_data  = b;
    step();
    sin_valid = 1'b0;
  endtask

  task automatic send_key(input logic [15:0] k, input logic p);
    for (int i = 0; i < 16; i++) beat(k[i]);
    beat(p);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; sin_valid = 1'b0; sin_data = 1'b0;
    @(negedge clk);

    // 1: reset state, then a gap-free load of A5C3 with correct parity
    do_reset();
    chk("rst_key_out", 32'(key_out), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_load_err", 32'(load_err), 32'h0);
    chk("rst_sin_ready", 32'(sin_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    pulse_start();
    cycles = 1;
    chk("t1_ready_in_shift", 32'(sin_ready), 32'h1);
    chk("t1_busy_in_shift", 32'(busy), 32'h1);
    send_key(16'hA5C3, 1'b0);
    cycles += 17;
    chk("t1_check_ready", 32'(sin_ready), 32'h0);
    chk("t1_check_busy", 32'(busy), 32'h1);
    chk("t1_no_early_done", 32'(load_done), 32'h0);
    chk("t1_key_held", 32'(key_out), 32'h0);
    step();
    cycles++;
    chk("t1_load_done", 32'(load_done), 32'h1);
    chk("t1_latency", 32'(cycles), 32'd19);
    chk("t1_key_out", 32'(key_out), 32'hA5C3);
    chk("t1_key_valid", 32'(key_valid), 32'h1);
    step();
    chk("t1_done_one_cycle", 32'(load_done), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // 2: wrong parity after a fresh reset -> sticky error, nothing committed
    do_reset();
    pulse_start();
    done_seen = 0;
    for (int i = 0; i < 16; i++) beat(1'((16'hA5C3 >> i) & 16'h1));
    beat(1'b1);
    step();
    if (load_done) done_seen++;
    chk("t2_load_err", 32'(load_err), 32'h1);
    chk("t2_key_out", 32'(key_out), 32'h0);
    chk("t2_key_valid", 32'(key_valid), 32'h0);
    chk("t2_no_done", 32'(done_seen), 32'h0);
    chk("t2_idle", 32'(busy), 32'h0);
    step();
    chk("t2_err_sticky", 32'(load_err), 32'h1);

    // 3: 8001 with a bubble before every beat; a new start clears the error
    pulse_start();
    chk("t3_err_cleared", 32'(load_err), 32'h0);
    for (int i = 0; i < 17; i++) begin
      sin_valid = 1'b0;
      step();
      chk("t3_ready_gap", 32'(sin_ready), 32'h1);
      beat(i < 16 ? 1'((16'h8001 >> i) & 16'h1) : 1'b0);
    end
    step();
    chk("t3_key_out", 32'(key_out), 32'h8001);
    chk("t3_done", 32'(load_done), 32'h1);

    // 4: abort after 7 bits; start wins over a simultaneous beat
    pulse_start();
    for (int i = 0; i < 7; i++) beat(1'b1);
    load_start = 1'b1; sin_valid = 1'b1; sin_data = 1'b1;
    step();
    load_start = 1'b0; sin_valid = 1'b0;
    chk("t4_still_shift", 32'(busy), 32'h1);
    chk("t4_key_held", 32'(key_out), 32'h8001);
    send_key(16'h0001, 1'b1);
    step();
    chk("t4_key_out", 32'(key_out), 32'h0001);
    chk("t4_no_err", 32'(load_err), 32'h0);

    // 5: reload keeps the old key visible until the commit edge; start in CHECK is ignored
    pulse_start();
    send_key(16'hA5C3, 1'b0);
    step();
    chk("t5_first_key", 32'(key_out), 32'hA5C3);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      chk("t5_hold_key", 32'(key_out), 32'hA5C3);
      chk("t5_hold_valid", 32'(key_valid), 32'h1);
      beat(1'((16'h1234 >> i) & 16'h1));
    end
    beat(1'b1);
    chk("t5_hold_in_check", 32'(key_out), 32'hA5C3);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("t5_key_out", 32'(key_out), 32'h1234);
    chk("t5_done", 32'(load_done), 32'h1);
    chk("t5_start_ignored", 32'(busy), 32'h0);

    // 6: reset in the middle of SHIFT discards everything; next load still works
    pulse_start();
    for (int i = 0; i < 10; i++) beat(1'b1);
    rst_n = 1'b0;
    step();
    chk("t6_key_out", 32'(key_out), 32'h0);
    chk("t6_key_valid", 32'(key_valid), 32'h0);
    chk("t6_sin_ready", 32'(sin_ready), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    pulse_start();
    send_key(16'hA5C3, 1'b0);
    step();
    chk("t6_reload_key", 32'(key_out), 32'hA5C3);
    chk("t6_reload_valid", 32'(key_valid), 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
